raster_sample_iter: RTL

Raster-order sample iterator that sits directly upstream of the sample-test stage. It accepts one triangle per handshake, together with its pre-snapped bounding box and the subsample rate. It then walks every sample position in the box, one sample per clock, presenting triangle, color and sample location at R16 for the inside-triangle test. While a box is being walked, it back-pressures the bounding-box stage through a ready signal.

---
 rtl/raster_sample_iter_if.sv | 29 ++
 rtl/raster_sample_iter.sv | 109 ++++++++++
 2 files changed

// File: rtl/raster_sample_iter_if.sv
// Triangle/box handshake from the bounding-box stage into the sample iterator,
// plus the R16 triangle/sample bundle handed to the sample-test stage.
interface raster_sample_iter_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U  [COLORS];
  logic signed [SIGFIG-1:0] box_R14S    [2][2];
  logic                     validTri_R14H;
  logic        [3:0]        subSample_R14U;
  logic                     ready_R14H;
  logic signed [SIGFIG-1:0] tri_R16S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R16U  [COLORS];
  logic signed [SIGFIG-1:0] sample_R16S [2];
  logic                     validSamp_R16H;

  modport master (
    output tri_R14S, color_R14U, box_R14S, validTri_R14H, subSample_R14U,
    input  ready_R14H, tri_R16S, color_R16U, sample_R16S, validSamp_R16H
  );

  modport slave (
    input  tri_R14S, color_R14U, box_R14S, validTri_R14H, subSample_R14U,
    output ready_R14H, tri_R16S, color_R16U, sample_R16S, validSamp_R16H
  );
endinterface

// File: rtl/raster_sample_iter.sv
// Raster-order sample iterator: walks every subsample grid point of a triangle's box, one per clock.
// Optional RASTER_SAMPLE_ITER_PERF_EN adds triangle/sample performance counters.
module raster_sample_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic clk,
  input  logic rst,
  raster_sample_iter_if.slave bus
`ifdef RASTER_SAMPLE_ITER_PERF_EN
  ,
  output logic [31:0] triCount_R16U,
  output logic [31:0] sampCount_R16U
`endif
);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_TEST = 1'b1;
  localparam logic [SIGFIG-1:0] ONE = {{(SIGFIG-1){1'b0}}, 1'b1};

  logic [0:0]               state_r;
  logic signed [SIGFIG-1:0] ll_x_r, ur_x_r, ur_y_r, x_r, y_r;
  logic        [SIGFIG-1:0] step_r, step_s;
  logic signed [SIGFIG:0]   nx_s, ny_s;
  logic fit_x_s, fit_y_s, last_s, ready_s, accept_s, nonempty_s;

  // Step decode, next-point arithmetic (one guard bit) and handshake.
  always_comb begin
    case (bus.subSample_R14U)
      4'b1000: step_s = ONE << RADIX;
      4'b0100: step_s = ONE << (RADIX - 1);
      4'b0010: step_s = ONE << (RADIX - 2);
      4'b0001: step_s = ONE << (RADIX - 3);
      default: step_s = ONE << RADIX;
    endcase
    nx_s       = $signed({x_r[SIGFIG-1], x_r}) + $signed({1'b0, step_r});
    ny_s       = $signed({y_r[SIGFIG-1], y_r}) + $signed({1'b0, step_r});
    fit_x_s    = nx_s <= $signed({ur_x_r[SIGFIG-1], ur_x_r});
    fit_y_s    = ny_s <= $signed({ur_y_r[SIGFIG-1], ur_y_r});
    last_s     = (state_r == ST_TEST) && !fit_x_s && !fit_y_s;
    ready_s    = !rst && ((state_r == ST_WAIT) || last_s);
    accept_s   = bus.validTri_R14H && ready_s;
    nonempty_s = (bus.box_R14S[0][0] <= bus.box_R14S[1][0]) &&
                 (bus.box_R14S[0][1] <= bus.box_R14S[1][1]);
  end

  assign bus.ready_R14H     = ready_s;
  assign bus.validSamp_R16H = (state_r == ST_TEST);
  assign bus.sample_R16S[0] = x_r;
  assign bus.sample_R16S[1] = y_r;

  // Walk state, latched triangle/box and current sample position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_WAIT;
      ll_x_r  <= {SIGFIG{1'b0}};
      ur_x_r  <= {SIGFIG{1'b0}};
      ur_y_r  <= {SIGFIG{1'b0}};
      x_r     <= {SIGFIG{1'b0}};
      y_r     <= {SIGFIG{1'b0}};
      step_r  <= {SIGFIG{1'b0}};
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          bus.tri_R16S[v][a] <= {SIGFIG{1'b0}};
      for (int c = 0; c < COLORS; c++)
        bus.color_R16U[c] <= {SIGFIG{1'b0}};
    end else if (accept_s) begin
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          bus.tri_R16S[v][a] <= bus.tri_R14S[v][a];
      for (int c = 0; c < COLORS; c++)
        bus.color_R16U[c] <= bus.color_R14U[c];
      ll_x_r  <= bus.box_R14S[0][0];
      ur_x_r  <= bus.box_R14S[1][0];
      ur_y_r  <= bus.box_R14S[1][1];
      x_r     <= bus.box_R14S[0][0];
      y_r     <= bus.box_R14S[0][1];
      step_r  <= step_s;
      // An empty box is consumed without ever entering the walk.
      state_r <= nonempty_s ? ST_TEST : ST_WAIT;
    end else if (state_r == ST_TEST) begin
      if (fit_x_s) begin
        x_r <= nx_s[SIGFIG-1:0];
      end else if (fit_y_s) begin
        x_r <= ll_x_r;
        y_r <= ny_s[SIGFIG-1:0];
      end else begin
        state_r <= ST_WAIT;
      end
    end
  end

`ifdef RASTER_SAMPLE_ITER_PERF_EN
  // Free-running wrap-around counters of accepted triangles and emitted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      triCount_R16U  <= 32'd0;
      sampCount_R16U <= 32'd0;
    end else begin
      triCount_R16U  <= triCount_R16U + {31'd0, accept_s};
      sampCount_R16U <= sampCount_R16U + {31'd0, (state_r == ST_TEST)};
    end
  end
`endif

endmodule
